mmio_mem_ctrl: RTL and testbench

MMIO_MEM_CTRL -- requirements
Module: mmio_mem_ctrl

---
 rtl/mmio_mem_ctrl_pkg.sv | 25 ++
 rtl/mmio_byte_ram.sv | 59 +++++
 rtl/mmio_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_mmio_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_mem_ctrl_pkg.sv
// Shared encodings, FSM state type and default geometry for the MMIO/memory controller.
package mmio_mem_ctrl_pkg;

  localparam int DEF_BUS_WIDTH  = 32;
  localparam int DEF_I_MEM_SIZE = 32;
  localparam int DEF_MMIO_BASE  = 64;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return (size == SZ_HALF && lsb[0]) || (size == SZ_WORD && lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mmio_byte_ram.sv
// Little-endian byte RAM: synchronous byte-lane write, asynchronous read with
// byte/half sign or zero extension. No flow control; one access per cycle.
module mmio_byte_ram
  import mmio_mem_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int RAM_BYTES = 256
) (
  input  logic                         clk,
  input  logic                         wr_vld,
  input  logic [$clog2(RAM_BYTES)-1:0] addr,
  input  logic [1:0]                   size,
  input  logic                         sz_ex,
  input  logic [BUS_WIDTH-1:0]         wr_dat,
  output logic [BUS_WIDTH-1:0]         rd_dat
);

  localparam int AW = $clog2(RAM_BYTES);

  logic [7:0]    mem [RAM_BYTES];
  logic [AW-1:0] lane_addr [4];
  logic [3:0]    lane_en;
  logic [31:0]   word;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr + AW'(i);
    end
  end

  always_comb begin
    lane_en = 4'b1111;
    case (size)
      SZ_BYTE: lane_en = 4'b0001;
      SZ_HALF: lane_en = 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[lane_addr[i]] <= wr_dat[8*i +: 8];
      end
    end
  end

  assign word = {mem[lane_addr[3]], mem[lane_addr[2]], mem[lane_addr[1]], mem[lane_addr[0]]};

  always_comb begin
    rd_dat = BUS_WIDTH'(word);
    case (size)
      SZ_BYTE: rd_dat = {{(BUS_WIDTH-8){sz_ex & word[7]}}, word[7:0]};
      SZ_HALF: rd_dat = {{(BUS_WIDTH-16){sz_ex & word[15]}}, word[15:0]};
      default: rd_dat = BUS_WIDTH'(word);
    endcase
  end

endmodule

// File: rtl/mmio_mem_ctrl.sv
// Single-outstanding memory/MMIO access controller; ready pulses WAIT_STATES+1 cycles
// after an accepted req, and further reqs are ignored until the access completes.
module mmio_mem_ctrl
  import mmio_mem_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int RAM_BYTES   = 256,
  parameter int I_MEM_SIZE  = DEF_I_MEM_SIZE,
  parameter int MMIO_BASE   = DEF_MMIO_BASE,
  parameter int NUM_IO      = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req,
  input  logic                        wr_en,
  input  logic [BUS_WIDTH-1:0]        address,
  input  logic [BUS_WIDTH-1:0]        wr_data,
  input  logic [1:0]                  mem_size,
  input  logic                        sz_ex,
  output logic [BUS_WIDTH-1:0]        rd_data,
  output logic                        ready,
  output logic                        err,
  input  logic [NUM_IO*BUS_WIDTH-1:0] mmio_in,
  output logic [NUM_IO*BUS_WIDTH-1:0] mmio_out
);

  localparam int RAM_AW = $clog2(RAM_BYTES);
  localparam int CH_W   = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [BUS_WIDTH-1:0] MMIO_LO = BUS_WIDTH'(MMIO_BASE);
  localparam logic [BUS_WIDTH-1:0] MMIO_HI = BUS_WIDTH'(MMIO_BASE + 4*NUM_IO);
  localparam logic [BUS_WIDTH-1:0] IMEM_HI = BUS_WIDTH'(I_MEM_SIZE);
  localparam logic [BUS_WIDTH-1:0] RAM_HI  = BUS_WIDTH'(RAM_BYTES);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                            state;
  logic [3:0]                        cnt;
  logic                              ready_q;
  logic [BUS_WIDTH-1:0]              addr_q;
  logic [BUS_WIDTH-1:0]              wdat_q;
  logic                              wr_q;
  logic [1:0]                        size_q;
  logic                              ex_q;
  logic [BUS_WIDTH-1:0]              rd_hold;
  logic [NUM_IO-1:0][BUS_WIDTH-1:0]  mmio_q;

  logic                 hit_mmio;
  logic                 fault;
  logic                 ram_wr;
  logic                 mmio_wr;
  logic [BUS_WIDTH-1:0] mmio_off;
  logic [CH_W-1:0]      ch;
  logic [BUS_WIDTH-1:0] ram_rd;
  logic [BUS_WIDTH-1:0] rd_now;

  assign mmio_off = addr_q - MMIO_LO;
  assign ch       = mmio_off[CH_W+1:2];
  assign hit_mmio = (addr_q >= MMIO_LO) && (addr_q < MMIO_HI);

  // Instruction-region writes share the fault outcome: err, zero data, nothing stored.
  always_comb begin
    fault = 1'b0;
    if (size_q == SZ_RSVD || misaligned(size_q, addr_q[1:0])) begin
      fault = 1'b1;
    end else if (hit_mmio) begin
      fault = (size_q != SZ_WORD);
    end else if (addr_q < IMEM_HI) begin
      fault = wr_q;
    end else begin
      fault = (addr_q >= RAM_HI);
    end
  end

  assign ram_wr  = ready_q && wr_q && !fault && !hit_mmio;
  assign mmio_wr = ready_q && wr_q && !fault && hit_mmio;

  always_comb begin
    rd_now = '0;
    if (!fault && !wr_q) begin
      rd_now = hit_mmio ? mmio_in[32'(ch)*BUS_WIDTH +: BUS_WIDTH] : ram_rd;
    end
  end

  mmio_byte_ram #(
    .BUS_WIDTH (BUS_WIDTH),
    .RAM_BYTES (RAM_BYTES)
  ) u_ram (
    .clk    (clk),
    .wr_vld (ram_wr),
    .addr   (addr_q[RAM_AW-1:0]),
    .size   (size_q),
    .sz_ex  (ex_q),
    .wr_dat (wdat_q),
    .rd_dat (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      ex_q    <= 1'b0;
      rd_hold <= '0;
      mmio_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= address;
            wdat_q <= wr_data;
            wr_q   <= wr_en;
            size_q <= mem_size;
            ex_q   <= sz_ex;
            if (WAIT_STATES == 0) begin
              state   <= DONE;
              ready_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          rd_hold <= rd_now;
          if (mmio_wr) mmio_q[ch] <= wdat_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign err      = ready_q & fault;
  assign rd_data  = ready_q ? rd_now : rd_hold;
  assign mmio_out = mmio_q;

endmodule

// File: tb/tb_mmio_mem_ctrl.sv
// Bench for mmio_mem_ctrl: three instances (WAIT_STATES 1, 3, 0), directed vector table,
// hand-written reset/hold sequences and a randomized run against a byte-array model.
module tb_mmio_mem_ctrl;

  logic         clk;
  logic         rst_v   [3];
  logic         req_v   [3];
  logic         wr_v    [3];
  logic [31:0]  addr_v  [3];
  logic [31:0]  wd_v    [3];
  logic [1:0]   sz_v    [3];
  logic         ex_v    [3];
  logic [31:0]  rd_v    [3];
  logic         rdy_v   [3];
  logic         err_v   [3];
  logic [127:0] mi_v    [3];
  logic [127:0] mo_v    [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mmio_mem_ctrl #(
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .req      (req_v[g]),
      .wr_en    (wr_v[g]),
      .address  (addr_v[g]),
      .wr_data  (wd_v[g]),
      .mem_size (sz_v[g]),
      .sz_ex    (ex_v[g]),
      .rd_data  (rd_v[g]),
      .ready    (rdy_v[g]),
      .err      (err_v[g]),
      .mmio_in  (mi_v[g]),
      .mmio_out (mo_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state for instance 0: byte array with known-byte flags, MMIO outputs.
  logic [7:0]   ram_m   [256];
  bit           known_m [256];
  logic [127:0] mo_m;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    bit          ex;
    logic [31:0] mi1;
    bit          e;
    bit          chk_rd;
    logic [31:0] rd;
    bit          chk_ch2;
    logic [31:0] ch2;
  } vec_t;

  vec_t        tab [$];
  bit          hold_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] rd, r1, r2, exp_rd;
  bit          e, exp_e, known;
  int          pulses;

  function automatic int ws(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit ex,
                        output logic [31:0] rd_o, output bit e_o);
    int lat;
    bit got;
    @(posedge clk); #1;
    req_v[d] = 1'b1; wr_v[d] = wr; addr_v[d] = a; wd_v[d] = wd; sz_v[d] = sz; ex_v[d] = ex;
    @(posedge clk); #1;
    // Scramble the request fields: the access must use only the latched copy.
    req_v[d] = 1'b0; wr_v[d] = ~wr; addr_v[d] = $urandom; wd_v[d] = $urandom;
    sz_v[d] = 2'($urandom); ex_v[d] = ~ex;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 40) begin
      if (rdy_v[d]) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk($sformatf("latency_dut%0d", d), 128'(lat), 128'(ws(d) + 1));
    rd_o = rd_v[d];
    e_o  = err_v[d];
    @(posedge clk); #1;
    chk("ready_single_cycle", 128'(rdy_v[d]), 128'(0));
    chk("err_outside_ready", 128'(err_v[d]), 128'(0));
    chk("rd_data_held", 128'(rd_v[d]), 128'(rd_o));
  endtask

  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit ex, input logic [127:0] mi,
                       output bit e_o, output logic [31:0] rd_o, output bit known_o);
    int n;
    longint v;
    e_o = 1'b0; rd_o = '0; known_o = !wr;
    n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    if (sz == 2'd3 || (a % n) != 0) e_o = 1'b1;
    else if (a >= 64 && a < 80) begin
      if (sz != 2'd2) e_o = 1'b1;
      else if (wr) mo_m[((a - 64) / 4) * 32 +: 32] = wd;
      else rd_o = mi[((a - 64) / 4) * 32 +: 32];
    end else if (a < 32 && wr) e_o = 1'b1;
    else if (a >= 256) e_o = 1'b1;
    else if (wr) begin
      for (int i = 0; i < n; i++) begin
        ram_m[a + i]   = wd[8*i +: 8];
        known_m[a + i] = 1'b1;
      end
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        if (!known_m[a + i]) known_o = 1'b0;
        v = v + (longint'(ram_m[a + i]) << (8 * i));
      end
      if (ex && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
      rd_o = v[31:0];
    end
    if (e_o) known_o = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b1; req_v[d] = 1'b0; wr_v[d] = 1'b0; addr_v[d] = '0;
      wd_v[d] = '0; sz_v[d] = 2'd0; ex_v[d] = 1'b0; mi_v[d] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      ram_m[i] = '0;
      known_m[i] = 1'b0;
    end
    mo_m = '0;

    // wr, addr, wdata, size, ex, mmio ch1, err, chk_rd, rd, chk_ch2, ch2
    tab.push_back('{1, 32'h80, 32'hDEADBEEF, 2'd2, 0, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 32'h80, 32'h0, 2'd2, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0});
    tab.push_back('{0, 32'h83, 32'h0, 2'd0, 1, 0, 0, 1, 32'hFFFFFFDE, 0, 0});
    tab.push_back('{0, 32'h83, 32'h0, 2'd0, 0, 0, 0, 1, 32'h000000DE, 0, 0});
    tab.push_back('{0, 32'h81, 32'h0, 2'd1, 1, 0, 1, 1, 32'h0, 0, 0});
    tab.push_back('{1, 32'h48, 32'h12345678, 2'd2, 0, 0, 0, 0, 0, 1, 32'h12345678});
    tab.push_back('{1, 32'h48, 32'h0000FFFF, 2'd1, 0, 0, 1, 1, 32'h0, 1, 32'h12345678});
    tab.push_back('{0, 32'h44, 32'h0, 2'd2, 0, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 0, 0});
    tab.push_back('{0, 32'h44, 32'h0, 2'd1, 0, 32'hA5A5A5A5, 1, 1, 32'h0, 0, 0});
    tab.push_back('{0, 32'hFF, 32'h0, 2'd1, 0, 0, 1, 1, 32'h0, 0, 0});
    tab.push_back('{0, 32'h80, 32'h0, 2'd3, 0, 0, 1, 1, 32'h0, 0, 0});
    tab.push_back('{0, 32'h100, 32'h0, 2'd2, 0, 0, 1, 1, 32'h0, 0, 0});
    tab.push_back('{1, 32'h84, 32'h9ABC80FF, 2'd2, 0, 0, 0, 0, 0, 0, 0});
    tab.push_back('{1, 32'h85, 32'hFFFFFF7A, 2'd0, 0, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 32'h84, 32'h0, 2'd1, 1, 0, 0, 1, 32'h00007AFF, 0, 0});
    tab.push_back('{0, 32'h86, 32'h0, 2'd1, 1, 0, 0, 1, 32'hFFFF9ABC, 0, 0});
    tab.push_back('{0, 32'h86, 32'h0, 2'd1, 0, 0, 0, 1, 32'h00009ABC, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready_dut%0d", d), 128'(rdy_v[d]), 128'(0));
      chk($sformatf("reset_err_dut%0d", d), 128'(err_v[d]), 128'(0));
      chk($sformatf("reset_rd_dut%0d", d), 128'(rd_v[d]), 128'(0));
      chk($sformatf("reset_mmio_dut%0d", d), mo_v[d], 128'(0));
    end

    foreach (tab[i]) begin
      mi_v[0] = 128'(tab[i].mi1) << 32;
      access(0, tab[i].wr, tab[i].a, tab[i].wd, tab[i].sz, tab[i].ex, rd, e);
      model(tab[i].wr, tab[i].a, tab[i].wd, tab[i].sz, tab[i].ex, mi_v[0], exp_e, exp_rd, known);
      chk($sformatf("vec%0d_err", i), 128'(e), 128'(tab[i].e));
      if (tab[i].chk_rd) chk($sformatf("vec%0d_rd", i), 128'(rd), 128'(tab[i].rd));
      if (tab[i].chk_ch2) chk($sformatf("vec%0d_ch2", i), 128'(mo_v[0][95:64]), 128'(tab[i].ch2));
    end

    // Instruction-region write is dropped: the word reads back unchanged.
    access(0, 0, 32'h10, 32'h0, 2'd2, 0, r1, e);
    chk("imem_read_err", 128'(e), 128'(0));
    access(0, 1, 32'h10, 32'h11111111, 2'd2, 0, rd, e);
    chk("imem_write_err", 128'(e), 128'(1));
    access(0, 0, 32'h10, 32'h0, 2'd2, 0, r2, e);
    chk("imem_unchanged", 128'(r2), 128'(r1));

    for (int it = 0; it < 200; it++) begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      bit          wr, ex;
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 31);
        1: a = $urandom_range(60, 84);
        2: a = $urandom_range(80, 255);
        3: a = $urandom_range(240, 270);
        default: a = $urandom_range(0, 511);
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wr = $urandom_range(0, 1) == 1;
      ex = $urandom_range(0, 1) == 1;
      wd = $urandom;
      mi_v[0] = {$urandom, $urandom, $urandom, $urandom};
      access(0, wr, a, wd, sz, ex, rd, e);
      model(wr, a, wd, sz, ex, mi_v[0], exp_e, exp_rd, known);
      chk($sformatf("rand%0d_err a=%0h sz=%0d wr=%0d", it, a, sz, wr), 128'(e), 128'(exp_e));
      if (known) chk($sformatf("rand%0d_rd a=%0h sz=%0d", it, a, sz), 128'(rd), 128'(exp_rd));
      chk($sformatf("rand%0d_mmio_out", it), mo_v[0], mo_m);
    end

    // WAIT_STATES=3: reset in the cycle after an accepted write abandons it.
    access(1, 1, 32'h90, 32'hCAFEF00D, 2'd2, 0, rd, e);
    chk("ws3_write_err", 128'(e), 128'(0));
    access(1, 1, 32'h40, 32'h0BADF00D, 2'd2, 0, rd, e);
    chk("ws3_mmio_ch0", 128'(mo_v[1][31:0]), 128'(32'h0BADF00D));
    @(posedge clk); #1;
    req_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 32'h90; wd_v[1] = 32'h55555555; sz_v[1] = 2'd2;
    @(posedge clk); #1;
    req_v[1] = 1'b0; rst_v[1] = 1'b1;
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    chk("abandon_mmio_cleared", mo_v[1], 128'(0));
    chk("abandon_rd_cleared", 128'(rd_v[1]), 128'(0));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pulses += int'(rdy_v[1]);
    end
    chk("abandon_no_ready", 128'(pulses), 128'(0));
    // Reset wins over a request in the same cycle.
    @(posedge clk); #1;
    req_v[1] = 1'b1; rst_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 32'h90;
    wd_v[1] = 32'h66666666; sz_v[1] = 2'd2;
    @(posedge clk); #1;
    req_v[1] = 1'b0; rst_v[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pulses += int'(rdy_v[1]);
    end
    chk("rst_priority_no_ready", 128'(pulses), 128'(0));
    access(1, 0, 32'h90, 32'h0, 2'd2, 0, rd, e);
    chk("abandon_ram_kept", 128'(rd), 128'(32'hCAFEF00D));

    // WAIT_STATES=0: held req completes every other cycle.
    @(posedge clk); #1;
    req_v[2] = 1'b1; wr_v[2] = 1'b0; addr_v[2] = 32'h80; sz_v[2] = 2'd2; ex_v[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_ready%0d", i), 128'(rdy_v[2]), 128'(hold_exp[i]));
      if (i == 3) req_v[2] = 1'b0;
    end
    access(2, 0, 32'h100, 32'h0, 2'd2, 0, rd, e);
    chk("ws0_oob_err", 128'(e), 128'(1));
    chk("ws0_oob_rd", 128'(rd), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
